// File: rtl/rvx_playback_buffer.sv
// rvx_playback_buffer: indexed sample store replayed in index order over valid/ready.
// Optional output register stage: define RVX_PLAYBACK_BUFFER_REG_OUT_EN.
module rvx_playback_buffer #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 1,
    parameter int CIRCULAR = 0,
    parameter int BW_COUNT = 16,
    localparam int BW_INDEX = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BW_LEN   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_enable,
    input  logic [BW_INDEX-1:0] load_index,
    input  logic [WIDTH-1:0]    load_data,
    input  logic [BW_LEN-1:0]   play_length,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [WIDTH-1:0]    tx_data,
    output logic                tx_first,
    output logic                tx_last,
    output logic                done,
    output logic [BW_COUNT-1:0] tx_count
);

    localparam logic [1:0] S_IDLE     = 2'd0;
`ifdef RVX_PLAYBACK_BUFFER_REG_OUT_EN
    localparam logic [1:0] S_PREFETCH = 2'd1;
`endif
    localparam logic [1:0] S_PLAY     = 2'd2;

    localparam logic [BW_LEN-1:0]  LEN_MAX = BW_LEN'(DEPTH);
    localparam logic [BW_INDEX:0]  IDX_END = (BW_INDEX + 1)'(DEPTH);

    logic [WIDTH-1:0]    mem [0:DEPTH-1];
    logic [1:0]          state;
    logic [BW_INDEX-1:0] ptr;
    logic [BW_INDEX-1:0] ptr_next;
    logic [BW_LEN-1:0]   len_q;
    logic [BW_LEN-1:0]   len_sel;
    logic [BW_COUNT-1:0] count_q;
    logic                done_q;
    logic                fire;
    logic                at_last;
    logic                load_ok;

    assign tx_valid = (state == S_PLAY);
    assign busy     = (state != S_IDLE);
    assign fire     = tx_valid && tx_ready;
    assign at_last  = ((BW_LEN'(ptr) + BW_LEN'(1)) == len_q);
    assign tx_first = (ptr == '0);
    assign tx_last  = at_last;
    assign done     = done_q;
    assign tx_count = count_q;
    assign load_ok  = load_enable && (state == S_IDLE)
                   && ({1'b0, load_index} < IDX_END);

    // Length clamp: zero or oversize requests play the whole buffer.
    always_comb begin
        len_sel = play_length;
        unique case (1'b1)
            (play_length == '0):     len_sel = LEN_MAX;
            (play_length > LEN_MAX): len_sel = LEN_MAX;
            default:                 len_sel = play_length;
        endcase
    end

    // Next read index; wraps to zero after the last played entry.
    always_comb begin
        ptr_next = ptr + BW_INDEX'(1);
        if (at_last) begin
            ptr_next = '0;
        end
    end

    // Sample store; loader writes only land while idle.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_index] <= load_data;
        end
    end

    // Playback sequencer: pointer, length, beat counter, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            len_q   <= LEN_MAX;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q   <= len_sel;
                        ptr     <= '0;
                        count_q <= '0;
`ifdef RVX_PLAYBACK_BUFFER_REG_OUT_EN
                        state   <= S_PREFETCH;
`else
                        state   <= S_PLAY;
`endif
                    end
                end
`ifdef RVX_PLAYBACK_BUFFER_REG_OUT_EN
                S_PREFETCH: begin
                    state <= stop ? S_IDLE : S_PLAY;
                end
`endif
                S_PLAY: begin
                    if (fire) begin
                        count_q <= count_q + BW_COUNT'(1);
                        ptr     <= ptr_next;
                        if (at_last && (CIRCULAR == 0)) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    // An abort wins over completion: no done pulse.
                    if (stop) begin
                        state  <= S_IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RVX_PLAYBACK_BUFFER_REG_OUT_EN
    logic [WIDTH-1:0] data_q;

    // Output register: entry 0 fetched ahead, next entry on every beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (state == S_PREFETCH) begin
            data_q <= mem[0];
        end else if (fire) begin
            data_q <= mem[ptr_next];
        end
    end

    assign tx_data = data_q;
`else
    assign tx_data = mem[ptr];
`endif

endmodule

// File: tb/tb_rvx_playback_buffer.sv
// tb_rvx_playback_buffer: vector table, corner sequences and randomized
// reference-model comparison for rvx_playback_buffer (DEPTH=4, WIDTH=8).
module tb_rvx_playback_buffer;

`ifdef RVX_PLAYBACK_BUFFER_REG_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load_enable;
    logic [1:0]  load_index;
    logic [7:0]  load_data;
    logic [2:0]  play_length;
    logic        start, stop, tx_ready;
    logic        start_c, stop_c, ready_c;

    logic        busy, tx_valid, tx_first, tx_last, done;
    logic [7:0]  tx_data;
    logic [15:0] tx_count;
    logic        busy_c, valid_c, first_c, last_c, done_c;
    logic [7:0]  data_c;
    logic [15:0] count_c;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rvx_playback_buffer #(
        .WIDTH(8), .DEPTH(4), .CIRCULAR(0), .BW_COUNT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .load_enable(load_enable), .load_index(load_index),
        .load_data(load_data), .play_length(play_length),
        .start(start), .stop(stop), .busy(busy),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_first(tx_first), .tx_last(tx_last), .done(done),
        .tx_count(tx_count)
    );

    rvx_playback_buffer #(
        .WIDTH(8), .DEPTH(4), .CIRCULAR(1), .BW_COUNT(16)
    ) dutc (
        .clk(clk), .rst(rst),
        .load_enable(load_enable), .load_index(load_index),
        .load_data(load_data), .play_length(play_length),
        .start(start_c), .stop(stop_c), .busy(busy_c),
        .tx_valid(valid_c), .tx_ready(ready_c), .tx_data(data_c),
        .tx_first(first_c), .tx_last(last_c), .done(done_c),
        .tx_count(count_c)
    );

    typedef struct {
        bit         st, sp, rdy, le;
        logic [1:0] li;
        logic [7:0] ld;
        logic [2:0] pl;
        bit         eb, ev;
        logic [7:0] ed;
        bit         ef, el, edn;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input bit st, sp, rdy, le, input logic [1:0] li,
                       input logic [7:0] ld, input logic [2:0] pl,
                       input bit eb, ev, input logic [7:0] ed,
                       input bit ef, el, edn, input logic [15:0] ec);
        vec_t v;
        v.st = st; v.sp = sp; v.rdy = rdy; v.le = le;
        v.li = li; v.ld = ld; v.pl = pl;
        v.eb = eb; v.ev = ev; v.ed = ed;
        v.ef = ef; v.el = el; v.edn = edn; v.ec = ec;
        tbl.push_back(v);
    endtask

    // Start row; with the output register an extra prefetch cycle follows.
    task automatic add_start(input bit le, input logic [1:0] li,
                             input logic [7:0] ld, input logic [2:0] pl,
                             input logic [7:0] ed, input bit ef, el);
        if (LAT == 1) begin
            add(1, 0, 0, le, li, ld, pl, 1, 1, ed, ef, el, 0, 16'd0);
        end else begin
            add(1, 0, 0, le, li, ld, pl, 1, 0, 8'h00, 0, 0, 0, 16'd0);
            add(0, 0, 0, 0, 2'd0, 8'h00, 3'd0, 1, 1, ed, ef, el, 0, 16'd0);
        end
    endtask

    // Reference model state for the randomized run.
    int m_mem[4];
    int m_busy, m_pre, m_pos, m_len, m_count, m_done;

    initial begin
        int seq[7];
        bit le, st, sp, rdy, fire, mv;
        int li, ld, pl;

        rst = 1'b1;
        load_enable = 0; load_index = 0; load_data = 0; play_length = 0;
        start = 0; stop = 0; tx_ready = 0;
        start_c = 0; stop_c = 0; ready_c = 0;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(tx_count), 32'd0);
        chk("rst_valid_c", 32'(valid_c), 32'd0);
        chk("rst_count_c", 32'(count_c), 32'd0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 4; i++) begin
            load_enable = 1;
            load_index  = 2'(i);
            load_data   = 8'(8'h11 * (i + 1));
            cyc();
        end
        load_enable = 0;

        // Full one-shot playback.
        add_start(0, 2'd0, 8'h00, 3'd0, 8'h11, 1, 0);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h22, 0, 0, 0, 16'd1);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h33, 0, 0, 0, 16'd2);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h44, 0, 1, 0, 16'd3);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 1, 16'd4);
        add(0, 0, 0, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 0, 16'd4);
        // Length 2 with back-pressure.
        add_start(0, 2'd0, 8'h00, 3'd2, 8'h11, 1, 0);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h22, 0, 1, 0, 16'd1);
        add(0, 0, 0, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h22, 0, 1, 0, 16'd1);
        add(0, 0, 0, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h22, 0, 1, 0, 16'd1);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 1, 16'd2);
        add(0, 0, 0, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 0, 16'd2);
        // Load while playing is ignored.
        add_start(0, 2'd0, 8'h00, 3'd0, 8'h11, 1, 0);
        add(0, 0, 0, 1, 2'd0, 8'hFF, 3'd0, 1, 1, 8'h11, 1, 0, 0, 16'd0);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h22, 0, 0, 0, 16'd1);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h33, 0, 0, 0, 16'd2);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h44, 0, 1, 0, 16'd3);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 1, 16'd4);
        add_start(0, 2'd0, 8'h00, 3'd0, 8'h11, 1, 0);
        // Stop together with the second transfer.
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h22, 0, 0, 0, 16'd1);
        add(0, 1, 1, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 0, 16'd2);
        add(0, 0, 0, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 0, 16'd2);
        // Load and start together, length 1.
        add_start(1, 2'd0, 8'h5A, 3'd1, 8'h5A, 1, 1);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 1, 16'd1);
        add(0, 0, 0, 1, 2'd0, 8'h11, 3'd0, 0, 0, 8'h00, 0, 0, 0, 16'd1);
        // Oversize length clamps to DEPTH; stop in idle is harmless.
        add_start(0, 2'd0, 8'h00, 3'd5, 8'h11, 1, 0);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h22, 0, 0, 0, 16'd1);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h33, 0, 0, 0, 16'd2);
        add(0, 0, 1, 0, 2'd0, 8'h00, 3'd0, 1, 1, 8'h44, 0, 1, 0, 16'd3);
        add(0, 1, 0, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 0, 16'd3);
        add(0, 1, 0, 0, 2'd0, 8'h00, 3'd0, 0, 0, 8'h00, 0, 0, 0, 16'd3);

        foreach (tbl[i]) begin
            start = tbl[i].st; stop = tbl[i].sp; tx_ready = tbl[i].rdy;
            load_enable = tbl[i].le; load_index = tbl[i].li;
            load_data = tbl[i].ld; play_length = tbl[i].pl;
            cyc();
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("row%0d_valid", i), 32'(tx_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].edn));
            chk($sformatf("row%0d_count", i), 32'(tx_count), 32'(tbl[i].ec));
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_data", i), 32'(tx_data), 32'(tbl[i].ed));
                chk($sformatf("row%0d_first", i), 32'(tx_first), 32'(tbl[i].ef));
                chk($sformatf("row%0d_last", i), 32'(tx_last), 32'(tbl[i].el));
            end
        end
        start = 0; stop = 0; tx_ready = 0; load_enable = 0;

        // Circular playback of three entries for seven beats.
        seq = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33, 8'h11};
        play_length = 3'd3;
        start_c = 1;
        cyc();
        start_c = 0;
        ready_c = 1;
        if (LAT == 2) cyc();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("circ%0d_valid", i), 32'(valid_c), 32'd1);
            chk($sformatf("circ%0d_data", i), 32'(data_c), 32'(seq[i]));
            chk($sformatf("circ%0d_first", i), 32'(first_c), 32'(i % 3 == 0));
            chk($sformatf("circ%0d_last", i), 32'(last_c), 32'(i % 3 == 2));
            chk($sformatf("circ%0d_done", i), 32'(done_c), 32'd0);
            cyc();
        end
        chk("circ_count7", 32'(count_c), 32'd7);
        chk("circ_still_valid", 32'(valid_c), 32'd1);
        chk("circ_data_wrap", 32'(data_c), 32'h22);
        stop_c = 1; ready_c = 0;
        cyc();
        stop_c = 0;
        chk("circ_stop_valid", 32'(valid_c), 32'd0);
        chk("circ_stop_busy", 32'(busy_c), 32'd0);
        chk("circ_stop_count", 32'(count_c), 32'd7);
        chk("circ_stop_done", 32'(done_c), 32'd0);

        // Asynchronous reset in the middle of playback.
        play_length = 3'd0;
        start = 1;
        cyc();
        start = 0; tx_ready = 1;
        cyc();
        cyc();
        chk("mid_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(tx_count), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        tx_ready = 0;
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Randomized run against the reference model.
        m_mem = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_busy = 0; m_pre = 0; m_pos = 0; m_len = 4; m_count = 0; m_done = 0;
        for (int c = 0; c < 3000; c++) begin
            mv = (m_busy != 0) && (m_pre == 0);
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_valid", 32'(tx_valid), 32'(mv));
            chk("rnd_done", 32'(done), 32'(m_done));
            chk("rnd_count", 32'(tx_count), 32'(m_count));
            if (mv) begin
                chk("rnd_data", 32'(tx_data), 32'(m_mem[m_pos]));
                chk("rnd_first", 32'(tx_first), 32'(m_pos == 0));
                chk("rnd_last", 32'(tx_last), 32'(m_pos == m_len - 1));
            end

            le  = ($urandom % 4) == 0;
            li  = int'($urandom % 4);
            ld  = int'($urandom % 256);
            pl  = int'($urandom % 8);
            st  = ($urandom % 6) == 0;
            rdy = ($urandom % 3) != 0;
            sp  = ($urandom % 25) == 0;
            fire = mv && rdy;
            if (fire && (m_pos == m_len - 1)) sp = 0;

            load_enable = le; load_index = 2'(li); load_data = 8'(ld);
            play_length = 3'(pl); start = st; stop = sp; tx_ready = rdy;

            m_done = 0;
            if (m_busy == 0) begin
                if (le) m_mem[li] = ld;
                if (st) begin
                    m_busy = 1;
                    m_pre = LAT - 1;
                    m_pos = 0;
                    m_count = 0;
                    m_len = (pl == 0 || pl > 4) ? 4 : pl;
                end
            end else begin
                if (fire) begin
                    m_count = (m_count + 1) % 65536;
                    if (m_pos == m_len - 1) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_pos++;
                    end
                end else if (m_pre > 0) begin
                    m_pre--;
                end
                if (sp) m_busy = 0;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
